// File: rtl/risc_toy_pkg.sv
// risc_toy_pkg -- shared definitions for the risc_toy memory arbiter slice.
//   AW / DW            : memory word-address and data widths
//   DRW_WRITE/DRW_READ : encoding of the DRW / MRW direction bit
//   arb_state_t        : arbiter FSM state encoding
//   TMR_W              : width of the busy-cycle timeout counter
package risc_toy_pkg;

   localparam int unsigned AW    = 30;
   localparam int unsigned DW    = 32;
   localparam int unsigned TMR_W = 8;

   localparam logic DRW_WRITE = 1'b1;
   localparam logic DRW_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/risc_toy_arb_timer.sv
// risc_toy_arb_timer -- counts consecutive busy cycles of the arbiter and
// flags the cycle in which the TIMEOUT-th busy cycle is reached.
// Only built when ARB_TIMEOUT_EN is defined (the arbiter is its sole user).
//   CLK     : clock, rising edge
//   RST     : asynchronous active-high reset, clears the count
//   busy    : arbiter is waiting on the memory this cycle
//   expired : this is the TIMEOUT-th consecutive busy cycle
`ifdef ARB_TIMEOUT_EN
module risc_toy_arb_timer
   import risc_toy_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic CLK,
   input  logic RST,
   input  logic busy,
   output logic expired
);

   logic [TMR_W-1:0] cnt;

   // Count restarts from zero whenever the arbiter leaves the busy state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       cnt <= '0;
      else if (busy) cnt <= cnt + {{(TMR_W-1){1'b0}}, 1'b1};
      else           cnt <= '0;
   end

   assign expired = busy && (cnt == TMR_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/risc_toy_mem_arb.sv
// risc_toy_mem_arb -- arbitrates an instruction-fetch port and a data port
// onto one shared, fully registered memory port.
//   CLK, RST            : clock (rising edge), async active-high reset
//   IREQ/IADDR          : instruction request (level-held), word address
//   IVALID/INSTR        : one-cycle completion pulse, registered instruction
//   DREQ/DRW/DADDR/DWDATA : data request (level-held), direction, addr, store data
//   DVALID/DRDATA       : one-cycle completion pulse, registered load data
//   MREQ/MRW/MADDR/MWDATA : shared memory request port (registered)
//   MRDATA/MRDY         : memory read data and completion strobe
//   ERR                 : one-cycle timeout pulse alongside the aborted VALID
// Optional feature macro: ARB_TIMEOUT_EN (busy-cycle timeout with abort).
// Data wins ties unless it has taken MAX_DGRANT grants in a row while an
// instruction fetch was waiting.
module risc_toy_mem_arb
   import risc_toy_pkg::*;
#(
   parameter int unsigned MAX_DGRANT = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IREQ,
   input  logic [AW-1:0] IADDR,
   output logic          IVALID,
   output logic [DW-1:0] INSTR,
   input  logic          DREQ,
   input  logic          DRW,
   input  logic [AW-1:0] DADDR,
   input  logic [DW-1:0] DWDATA,
   output logic          DVALID,
   output logic [DW-1:0] DRDATA,
   output logic          MREQ,
   output logic          MRW,
   output logic [AW-1:0] MADDR,
   output logic [DW-1:0] MWDATA,
   input  logic [DW-1:0] MRDATA,
   input  logic          MRDY,
   output logic          ERR
);

   localparam logic [2:0] DG_MAX = 3'(MAX_DGRANT);

   arb_state_t state, state_nx;
   logic [2:0] dg_cnt;
   logic       starved, grant_d, grant_i, busy, finish, abort, tmo;

   assign busy    = (state == IBUSY) || (state == DBUSY);
   assign starved = IREQ && (dg_cnt == DG_MAX);
   assign finish  = busy && (MRDY || tmo);
   // A real MRDY in the expiry cycle takes precedence over the abort.
   assign abort   = busy && !MRDY && tmo;

`ifdef ARB_TIMEOUT_EN
   logic err_q;

   risc_toy_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .CLK     (CLK),
      .RST     (RST),
      .busy    (busy),
      .expired (tmo)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) err_q <= 1'b0;
      else     err_q <= abort;
   end

   assign ERR = err_q;
`else
   // TIMEOUT only has meaning when the timer is built.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo = 1'b0;
   assign ERR = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      grant_d  = 1'b0;
      grant_i  = 1'b0;
      case (state)
         IDLE: begin
            if (DREQ && !starved) begin
               grant_d  = 1'b1;
               state_nx = DBUSY;
            end else if (IREQ) begin
               grant_i  = 1'b1;
               state_nx = IBUSY;
            end
         end
         IBUSY, DBUSY: if (finish) state_nx = RESP;
         RESP:         state_nx = IDLE;
         default:      state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         dg_cnt <= '0;
         IVALID <= 1'b0;
         DVALID <= 1'b0;
         INSTR  <= '0;
         DRDATA <= '0;
         MREQ   <= 1'b0;
         MRW    <= 1'b0;
         MADDR  <= '0;
         MWDATA <= '0;
      end else begin
         state  <= state_nx;
         IVALID <= 1'b0;
         DVALID <= 1'b0;

         if (grant_d) begin
            MREQ   <= 1'b1;
            MRW    <= DRW;
            MADDR  <= DADDR;
            MWDATA <= DWDATA;
            if (!IREQ)                dg_cnt <= '0;
            else if (dg_cnt != DG_MAX) dg_cnt <= dg_cnt + 3'd1;
         end else if (grant_i) begin
            MREQ   <= 1'b1;
            MRW    <= DRW_READ;
            MADDR  <= IADDR;
            MWDATA <= '0;
            dg_cnt <= '0;
         end

         if (finish) begin
            MREQ <= 1'b0;
            if (state == IBUSY) begin
               IVALID <= 1'b1;
               INSTR  <= abort ? '0 : MRDATA;
            end else begin
               DVALID <= 1'b1;
               DRDATA <= (abort || (MRW == DRW_WRITE)) ? '0 : MRDATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_risc_toy_mem_arb.sv
// tb_risc_toy_mem_arb -- self-checking bench for risc_toy_mem_arb.
// Table of single transactions, directed multi-cycle sequences (tie-break,
// starvation limit, timeout, reset mid-access) and a randomized run checked
// against a transaction-level reference model.
module tb_risc_toy_mem_arb;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IREQ, IVALID, DREQ, DRW, DVALID, MREQ, MRW, MRDY, ERR;
   logic [29:0] IADDR, DADDR, MADDR;
   logic [31:0] INSTR, DWDATA, DRDATA, MWDATA, MRDATA;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   localparam int unsigned MAXG = 4;
   localparam int unsigned TMO  = 15;

   risc_toy_mem_arb #(.MAX_DGRANT(MAXG), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .IREQ(IREQ), .IADDR(IADDR), .IVALID(IVALID), .INSTR(INSTR),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
      .DVALID(DVALID), .DRDATA(DRDATA),
      .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA),
      .MRDATA(MRDATA), .MRDY(MRDY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_d;
      bit          rw;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int unsigned delay;
      logic [29:0] e_maddr;
      bit          e_mrw;
      logic [31:0] e_data;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] e_instr, e_drdata;
   logic [29:0] b2b_addr [7];
   bit          b2b_isd  [7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int unsigned idx);
      if (v.is_d) begin
         DREQ = 1'b1; DRW = v.rw; DADDR = v.addr; DWDATA = v.wdata;
      end else begin
         IREQ = 1'b1; IADDR = v.addr;
      end
      MRDY = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_grant", idx), {MREQ, MRW, MADDR}, {1'b1, v.e_mrw, v.e_maddr});
      if (v.is_d && v.rw) chk($sformatf("v%0d_wdata", idx), MWDATA, v.wdata);
      for (int unsigned d = 0; d < v.delay; d++) begin
         MRDATA = $urandom;
         @(negedge CLK);
         chk($sformatf("v%0d_hold%0d", idx, d), {MREQ, IVALID, DVALID, MADDR},
             {1'b1, 1'b0, 1'b0, v.e_maddr});
      end
      MRDY = 1'b1; MRDATA = v.mrdata;
      @(negedge CLK);
      if (v.is_d) e_drdata = v.e_data; else e_instr = v.e_data;
      chk($sformatf("v%0d_resp", idx), {MREQ, IVALID, DVALID, ERR}, {1'b0, !v.is_d, v.is_d, 1'b0});
      chk($sformatf("v%0d_data", idx), {INSTR, DRDATA}, {e_instr, e_drdata});
      IREQ = 1'b0; DREQ = 1'b0; MRDY = 1'b0; MRDATA = $urandom;
      @(negedge CLK);
      chk($sformatf("v%0d_after", idx), {MREQ, IVALID, DVALID, INSTR, DRDATA},
          {1'b0, 1'b0, 1'b0, e_instr, e_drdata});
   endtask

   // Transaction-level model: a request seen while the port is free is granted
   // (data first unless the fetch has already lost MAXG grants in a row), it
   // completes on the first MRDY, the VALID cycle is followed by one dead cycle.
   task automatic run_random(input int unsigned ncyc);
      int unsigned phase = 0;   // 0 port free, 1 access outstanding, 2 response cycle
      int unsigned consec = 0, wait_n = 0;
      bit          srv_d = 1'b0, srv_rw = 1'b0;
      logic [29:0] srv_addr = '0;
      logic [31:0] srv_wdata = '0, m_instr = '0, m_drdata = '0;
      bit          p_ireq = 1'b0, p_dreq = 1'b0, p_mrdy = 1'b0, p_drw = 1'b0;
      logic [29:0] p_iaddr = '0, p_daddr = '0;
      logic [31:0] p_dwdata = '0, p_mrdata = '0;
      bit          exp_iv, exp_dv, take_d, hold_i, hold_d;
      for (int unsigned c = 0; c < ncyc; c++) begin
         @(negedge CLK);
         exp_iv = 1'b0; exp_dv = 1'b0;
         if (phase == 0) begin
            if (p_dreq || p_ireq) begin
               take_d = p_dreq && !(p_ireq && consec >= MAXG);
               if (take_d) begin
                  consec    = p_ireq ? ((consec < MAXG) ? consec + 1 : MAXG) : 0;
                  srv_d     = 1'b1; srv_rw = p_drw; srv_addr = p_daddr; srv_wdata = p_dwdata;
               end else begin
                  consec    = 0;
                  srv_d     = 1'b0; srv_rw = 1'b0; srv_addr = p_iaddr;
               end
               phase  = 1;
               wait_n = 0;
            end
         end else if (phase == 1) begin
            if (p_mrdy) begin
               phase = 2;
               if (srv_d) begin exp_dv = 1'b1; m_drdata = srv_rw ? 32'h0 : p_mrdata; end
               else       begin exp_iv = 1'b1; m_instr  = p_mrdata; end
            end
         end else begin
            phase = 0;
         end
         chk($sformatf("rnd%0d_out", c), {MREQ, IVALID, DVALID, ERR, INSTR, DRDATA},
             {(phase == 1), exp_iv, exp_dv, 1'b0, m_instr, m_drdata});
         if (phase == 1) begin
            if (srv_d) chk($sformatf("rnd%0d_dport", c), {MADDR, MRW, MWDATA}, {srv_addr, srv_rw, srv_wdata});
            else       chk($sformatf("rnd%0d_iport", c), {MADDR, MRW}, {srv_addr, 1'b0});
         end
         hold_i = 1'b0; hold_d = 1'b0;
         if (exp_iv) begin IREQ = 1'b0; hold_i = 1'b1; end
         if (exp_dv) begin DREQ = 1'b0; hold_d = 1'b1; end
         if (!IREQ && !hold_i && $urandom_range(0, 3) == 0) begin
            IREQ = 1'b1; IADDR = 30'($urandom);
         end
         if (!DREQ && !hold_d && $urandom_range(0, 1) == 0) begin
            DREQ = 1'b1; DRW = 1'($urandom); DADDR = 30'($urandom); DWDATA = $urandom;
         end
         if (phase == 1) begin
            MRDY   = (wait_n >= 3) || ($urandom_range(0, 2) == 0);
            wait_n++;
         end else begin
            MRDY = ($urandom_range(0, 3) == 0);
         end
         MRDATA = $urandom;
         p_ireq = IREQ; p_iaddr = IADDR; p_dreq = DREQ; p_drw = DRW; p_daddr = DADDR;
         p_dwdata = DWDATA; p_mrdy = MRDY; p_mrdata = MRDATA;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n;
      logic [29:0] next_d;

      vecs[0] = '{1'b0, 1'b0, 30'h100,      32'h0,        32'hDEADBEEF, 0, 30'h100,      1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b0, 30'h3FFFFFFF, 32'h0,        32'h12345678, 2, 30'h3FFFFFFF, 1'b0, 32'h12345678};
      vecs[2] = '{1'b1, 1'b1, 30'h20,       32'h55,       32'hFFFFFFFF, 1, 30'h20,       1'b1, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 30'h3FFFFFFF, 32'h0,        32'h0F0F0F0F, 3, 30'h3FFFFFFF, 1'b0, 32'h0F0F0F0F};
      vecs[4] = '{1'b1, 1'b1, 30'h0,        32'hA5A5A5A5, 32'h00000011, 0, 30'h0,        1'b1, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 30'h1234,     32'h0,        32'hFFFFFFFF, 0, 30'h1234,     1'b0, 32'hFFFFFFFF};
      b2b_addr = '{30'h40, 30'h41, 30'h42, 30'h43, 30'h300, 30'h44, 30'h301};
      b2b_isd  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset with busy-looking inputs: everything must stay at zero.
      RST = 1'b1; IREQ = 1'b1; DREQ = 1'b1; DRW = 1'b1; MRDY = 1'b1;
      IADDR = 30'h5; DADDR = 30'h6; DWDATA = 32'h7; MRDATA = 32'h8;
      @(negedge CLK); @(negedge CLK);
      chk("reset_outs", {MREQ, MRW, MADDR, MWDATA, IVALID, DVALID, ERR, INSTR, DRDATA}, '0);
      IREQ = 1'b0; DREQ = 1'b0; DRW = 1'b0; MRDY = 1'b0;
      RST = 1'b0;
      @(negedge CLK);
      chk("post_reset_idle", {MREQ, IVALID, DVALID, ERR}, '0);
      e_instr = '0; e_drdata = '0;

      for (int unsigned i = 0; i < 6; i++) run_vec(vecs[i], i);

      // MRDY with nothing outstanding changes nothing.
      for (int unsigned i = 0; i < 3; i++) begin
         MRDY = 1'b1; MRDATA = 32'h11111111;
         @(negedge CLK);
         chk($sformatf("stray_mrdy%0d", i), {MREQ, IVALID, DVALID, INSTR, DRDATA},
             {1'b0, 1'b0, 1'b0, e_instr, e_drdata});
      end
      MRDY = 1'b0;

      // Memory never answers.
      DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h99;
      @(negedge CLK);
      n = 0;
`ifdef ARB_TIMEOUT_EN
      while (MREQ && n < 40) begin n++; @(negedge CLK); end
      chk("tmo_busy_cycles", n, TMO);
      e_drdata = '0;
      chk("tmo_resp", {MREQ, DVALID, IVALID, ERR, DRDATA}, {1'b0, 1'b1, 1'b0, 1'b1, e_drdata});
      DREQ = 1'b0;
      @(negedge CLK);
      chk("tmo_after", {MREQ, DVALID, ERR}, '0);
`else
      while (MREQ && n < 40) begin n++; @(negedge CLK); end
      chk("notmo_busy_cycles", n, 40);
      chk("notmo_no_resp", {DVALID, ERR, MADDR}, {1'b0, 1'b0, 30'h99});
      #1 RST = 1'b1;
      #1 chk("notmo_reset", {MREQ, DVALID, ERR, INSTR, DRDATA}, '0);
      e_instr = '0; e_drdata = '0;
      DREQ = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
`endif

      // Simultaneous requests: data write first, then the fetch.
      IREQ = 1'b1; IADDR = 30'h200;
      DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h20; DWDATA = 32'h55;
      @(negedge CLK);
      chk("tie_data_first", {MREQ, MRW, MADDR, MWDATA}, {1'b1, 1'b1, 30'h20, 32'h55});
      MRDY = 1'b1; MRDATA = 32'hAAAAAAAA;
      @(negedge CLK);
      e_drdata = '0;
      chk("tie_dvalid", {IVALID, DVALID, DRDATA}, {1'b0, 1'b1, e_drdata});
      DREQ = 1'b0; MRDY = 1'b0;
      @(negedge CLK);
      chk("tie_resp_gap", {MREQ, IVALID, DVALID}, '0);
      @(negedge CLK);
      chk("tie_instr_next", {MREQ, MRW, MADDR}, {1'b1, 1'b0, 30'h200});
      MRDY = 1'b1; MRDATA = 32'h0BADF00D;
      @(negedge CLK);
      e_instr = 32'h0BADF00D;
      chk("tie_ivalid", {IVALID, DVALID, INSTR, DRDATA}, {1'b1, 1'b0, e_instr, e_drdata});
      IREQ = 1'b0; MRDY = 1'b0;
      @(negedge CLK);

      // Back-to-back data with a waiting fetch: MAXG data grants, then the fetch.
      IREQ = 1'b1; IADDR = 30'h300;
      DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h40; next_d = 30'h41;
      @(negedge CLK);
      for (int k = 0; k < 7; k++) begin
         n = 0;
         while (!MREQ && n < 8) begin @(negedge CLK); n++; end
         chk($sformatf("b2b%0d_latency", k), n, 0);
         chk($sformatf("b2b%0d_grant", k), {MREQ, MRW, MADDR}, {1'b1, 1'b0, b2b_addr[k]});
         MRDY = 1'b1; MRDATA = 32'(k);
         @(negedge CLK);
         MRDY = 1'b0;
         chk($sformatf("b2b%0d_valid", k), {IVALID, DVALID}, {!b2b_isd[k], b2b_isd[k]});
         if (b2b_isd[k]) DREQ = 1'b0; else IREQ = 1'b0;
         @(negedge CLK);
         if (b2b_isd[k] && k < 5) begin DREQ = 1'b1; DADDR = next_d; next_d = next_d + 30'd1; end
         if (!b2b_isd[k] && k == 4) begin IREQ = 1'b1; IADDR = 30'h301; end
         @(negedge CLK);
      end

      // Reset in the middle of a data access.
      DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h77;
      @(negedge CLK);
      chk("rst_mid_busy", {MREQ, MADDR}, {1'b1, 30'h77});
      #2 RST = 1'b1; MRDY = 1'b1; MRDATA = 32'h33333333;
      #1 chk("rst_async", {MREQ, DVALID, IVALID, ERR, INSTR, DRDATA}, '0);
      @(negedge CLK);
      chk("rst_held", {MREQ, DVALID}, '0);
      RST = 1'b0; MRDY = 1'b0;
      @(negedge CLK);
      chk("rst_regrant", {MREQ, DVALID, MADDR}, {1'b1, 1'b0, 30'h77});
      MRDY = 1'b1; MRDATA = 32'hCAFEF00D;
      @(negedge CLK);
      chk("rst_complete", {DVALID, DRDATA}, {1'b1, 32'hCAFEF00D});
      DREQ = 1'b0; MRDY = 1'b0;
      @(negedge CLK);

      // Randomized traffic from a clean reset.
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      run_random(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/risc_toy_mem_arb.md
RISC_TOY_MEM_ARB -- requirements
Module: risc_toy_mem_arb

Interface
REQ-001 SHALL have parameter MAX_DGRANT, 4, max consecutive data grants while an instruction request waits (legal 1..7).
REQ-002 SHALL have parameter TIMEOUT, 15, busy cycles without MRDY before abort (legal 1..255; used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port IREQ  input  1  instruction fetch request, level-held until IVALID.
REQ-006 SHALL have port IADDR  input  30  instruction word address.
REQ-007 SHALL have port IVALID  output  1  one-cycle pulse: INSTR valid.
REQ-008 SHALL have port INSTR  output  32  fetched instruction, registered.
REQ-009 SHALL have port DREQ  input  1  data request, level-held until DVALID.
REQ-010 SHALL have port DRW  input  1  1 = write, 0 = read.
REQ-011 SHALL have ports DADDR input 30 and DWDATA input 32: data word address and store data.
REQ-012 SHALL have port DVALID  output  1  one-cycle pulse: data access complete.
REQ-013 SHALL have port DRDATA  output  32  load data, registered; 0 after a write.
REQ-014 SHALL have ports MREQ out 1, MRW out 1, MADDR out 30, MWDATA out 32: shared memory port, all registered.
REQ-015 SHALL have ports MRDATA in 32 and MRDY in 1: memory read data and completion strobe.
REQ-016 SHALL have port ERR  output  1  one-cycle timeout pulse, coincident with the aborted VALID.

Function
REQ-017 SHALL implement FSM states IDLE, IBUSY, DBUSY, RESP.
REQ-018 IDLE: DREQ and not starved -> DBUSY; else IREQ -> IBUSY; else stay.
REQ-019 Starved SHALL mean IREQ=1 and consecutive-data-grant count = MAX_DGRANT; IREQ then wins.
REQ-020 Grant count SHALL increment on a data grant with IREQ=1, clear on instruction grant or on a data grant with IREQ=0, saturating at MAX_DGRANT.
REQ-021 On grant, address/RW/write data SHALL be latched; MREQ=1 from the next cycle and held stable through the busy state.
REQ-022 IBUSY/DBUSY: MRDY=1 sampled -> RESP; MRDATA captured into INSTR (IBUSY) or into DRDATA (DBUSY read); MREQ drops the same edge.
REQ-023 RESP SHALL last exactly one cycle with the served VALID=1, then return to IDLE; no grant is decided in RESP.
REQ-024 Minimum latency: REQ sampled in IDLE at cycle t, MRDY at t+1 -> VALID at t+2; next grant no earlier than t+3.
REQ-025 Requester SHALL drop REQ by cycle t+3; a REQ still high in IDLE is a new request.
REQ-026 Simultaneous IREQ and DREQ with count < MAX_DGRANT SHALL grant data.
REQ-027 INSTR/DRDATA SHALL hold their last value outside RESP.
REQ-028 MRDY outside busy states SHALL be ignored.

Reset
REQ-029 RST=1 SHALL force IDLE, grant count 0, timer 0, all outputs 0, immediately and asynchronously.
REQ-030 Reset during IBUSY/DBUSY SHALL drop MREQ with no VALID; the pending request is re-arbitrated after release.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: busy-cycle timer; on reaching TIMEOUT without MRDY -> RESP with VALID=1, ERR=1, data 0.
REQ-032 Macro ARB_TIMEOUT_EN undefined: no timer, unbounded wait for MRDY, ERR tied 0.

Structure
REQ-033 Shared package risc_toy_pkg SHALL hold FSM state encoding, address width 30, data width 32, DRW write/read constants.
REQ-034 The timeout counter SHALL be sub-module risc_toy_arb_timer, instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-035 IREQ only, IADDR=0x100, MRDY at first busy cycle, MRDATA=0xDEADBEEF -> MADDR=0x100, IVALID at t+2, INSTR=0xDEADBEEF.
REQ-036 IREQ and DREQ together in IDLE, DRW=1, DADDR=0x20, DWDATA=0x55 -> data granted first (MRW=1, MWDATA=0x55), DVALID, then instruction granted.
REQ-037 DREQ re-asserted back-to-back, IREQ held, MAX_DGRANT=4 -> exactly 4 data grants, 5th grant instruction, count cleared.
REQ-038 ARB_TIMEOUT_EN, TIMEOUT=15, MRDY never -> MREQ high 15 cycles, then DVALID=1, ERR=1, DRDATA=0; without macro MREQ held indefinitely.
REQ-039 RST pulsed mid-DBUSY -> MREQ=0 same cycle, no DVALID; after release held DREQ re-granted, MREQ high 1 cycle later.
